// File: rtl/serial_operand_tx_pkg.sv
// Shared constants for the bit-serial operand transmitter.
// State encodings stay as plain constants so legacy code can match on them.
package serial_operand_tx_pkg;

    localparam int unsigned DEFAULT_WIDTH = 32;

    typedef logic [1:0] state_t;

    localparam state_t S_IDLE  = 2'd0;
    localparam state_t S_SHIFT = 2'd1;
    localparam state_t S_DONE  = 2'd2;

endpackage

// File: rtl/serial_operand_tx_piso.sv
// Parallel-in, serial-out left shifter with load, shift-enable and clear.
// The MSB is the serial output; zeros fill from the LSB side.
module piso_shift_reg #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             res,
    input  logic             clr,
    input  logic             load,
    input  logic             shift_en,
    input  logic [WIDTH-1:0] din,
    output logic             msb
);

    logic [WIDTH-1:0] sr;

    always_ff @(posedge clk) begin
        if (res || clr) begin
            sr <= '0;
        end else if (load) begin
            sr <= din;
        end else if (shift_en) begin
            sr <= {sr[WIDTH-2:0], 1'b0};
        end
    end

    assign msb = sr[WIDTH-1];

endmodule

// File: rtl/serial_operand_tx.sv
// Streams two captured operands MSB-first as framed bit pairs with
// ready/valid back-pressure; busy/done report progress to the sequencer.
module serial_operand_tx
    import serial_operand_tx_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH,
    parameter int unsigned IDXW  = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             res,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bit_ready,
    output logic             bit_valid,
    output logic             bit_a,
    output logic             bit_b,
    output logic             sop,
    output logic             eop,
    output logic [IDXW-1:0]  bit_idx,
    output logic             busy,
    output logic             done
);

    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(WIDTH - 1);

    state_t          state;
    state_t          state_nxt;
    logic [IDXW-1:0] cnt;
    logic [IDXW-1:0] cnt_nxt;

    logic in_idle;
    logic in_shift;
    logic in_done;
    logic load;
    logic accept;
    logic last;
    logic msb_a;
    logic msb_b;

    assign in_idle  = (state == S_IDLE);
    assign in_shift = (state == S_SHIFT);
    assign in_done  = (state == S_DONE);
    assign load     = in_idle & start;
    assign accept   = in_shift & bit_ready;
    assign last     = (cnt == LAST_IDX);

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt = S_SHIFT;
                    cnt_nxt   = '0;
                end
            end
            S_SHIFT: begin
                if (bit_ready) begin
                    // Final pair leaves cnt at WIDTH-1 instead of wrapping.
                    if (last) begin
                        state_nxt = S_DONE;
                    end else begin
                        cnt_nxt = cnt + IDXW'(1);
                    end
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (res) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    piso_shift_reg #(
        .WIDTH(WIDTH)
    ) u_sra (
        .clk      (clk),
        .res      (res),
        .clr      (in_done),
        .load     (load),
        .shift_en (accept),
        .din      (a),
        .msb      (msb_a)
    );

    piso_shift_reg #(
        .WIDTH(WIDTH)
    ) u_srb (
        .clk      (clk),
        .res      (res),
        .clr      (in_done),
        .load     (load),
        .shift_en (accept),
        .din      (b),
        .msb      (msb_b)
    );

    // Outputs depend on registered state only; bit_ready never reaches them.
    assign bit_valid = in_shift;
    assign bit_a     = in_shift & msb_a;
    assign bit_b     = in_shift & msb_b;
    assign sop       = in_shift & (cnt == '0);
    assign eop       = in_shift & last;
    assign bit_idx   = in_shift ? cnt : '0;
    assign busy      = in_shift | in_done;
    assign done      = in_done;

endmodule

// File: doc/serial_operand_tx.md
Name: serial_operand_tx

Overview:
- Transmit side of the bit-serial compare path.
- Loads two WIDTH-bit operands in parallel and streams them MSB-first, one bit pair per accepted cycle.
- Frames the stream with start-of-stream and end-of-stream strobes so a downstream bit-serial unit can consume it.
- Supports consumer back-pressure through bit_ready, and reports busy/done to the controlling sequencer.

Parameters:
- WIDTH, 32, operand width in bits (legal range: 2 or more).
- IDXW, $clog2(WIDTH), width of the bit-index output.

Ports:
- clk  input  1  system clock; all logic is updated on its rising edge.
- res  input  1  reset, synchronous and active-high.
- start  input  1  load request; sampled only in IDLE.
- a  input  WIDTH  operand A, captured when start is accepted.
- b  input  WIDTH  operand B, captured when start is accepted.
- bit_ready  input  1  consumer can accept the current bit pair.
- bit_valid  output  1  bit_a/bit_b/sop/eop/bit_idx are valid.
- bit_a  output  1  current MSB of the A shift register.
- bit_b  output  1  current MSB of the B shift register.
- sop  output  1  first bit pair of the stream (the MSB pair).
- eop  output  1  last bit pair of the stream (the LSB pair).
- bit_idx  output  IDXW  count of bit pairs already accepted (0..WIDTH-1).
- busy  output  1  a transfer is in progress.
- done  output  1  one-cycle pulse after the last bit pair is accepted.

Behaviour:
- Interface: one clock, clk; reset res is synchronous and active-high.
- Reset: state = IDLE, both shift registers = 0, counter = 0.
- Reset values of outputs: bit_valid, bit_a, bit_b, sop, eop, busy and done are all 0; bit_idx is 0.
- Reset takes priority over every other input and aborts a transfer in progress; no done pulse is produced.
- FSM has three states: IDLE, SHIFT, DONE.
- IDLE:
  - busy = 0, bit_valid = 0.
  - If start = 1: capture a into sra and b into srb, set cnt = 0, go to SHIFT.
- SHIFT:
  - busy = 1, bit_valid = 1.
  - bit_a = sra[WIDTH-1], bit_b = srb[WIDTH-1].
  - sop = (cnt == 0), eop = (cnt == WIDTH-1), bit_idx = cnt.
  - Accept condition: bit_valid & bit_ready. On accept, both registers shift left by 1 with zero fill and cnt increments.
  - Accept with eop = 1: go to DONE; cnt is not incremented (no wrap).
  - bit_ready = 0: registers, cnt and every output hold their values; a stall can last any number of cycles.
- DONE:
  - busy = 1, done = 1, bit_valid = 0; lasts exactly one cycle, then IDLE.
- start is ignored in SHIFT and DONE; a, b and start may change freely after capture without affecting the stream.
- Outputs are driven by combinational logic from registered state only. There is no combinational path from bit_ready to any output.
- Latency with bit_ready held at 1:
  - start is sampled at edge 0.
  - sop pair is visible during cycle 1.
  - eop pair is visible during cycle WIDTH.
  - done is high during cycle WIDTH+1; IDLE resumes in cycle WIDTH+2.
- Maximum throughput: one operand pair per WIDTH+2 cycles.
- start and res asserted in the same cycle: res wins and nothing is captured.
- bit_a and bit_b are don't-care while bit_valid = 0, but are driven 0 in IDLE and DONE for clean waveforms.

Decomposition:
- Shared package holds:
  - State encoding constants: S_IDLE = 2'd0, S_SHIFT = 2'd1, S_DONE = 2'd2.
  - Default operand width constant: 32.
- One natural sub-module, piso_shift_reg. It is a WIDTH-bit parallel-in, serial-out left shifter with load, shift-enable and clear, exposing its MSB.
- The top instantiates piso_shift_reg twice, once for A and once for B, and holds the FSM and counter.

Test Plan:
1. Reset, then start with a = 32'hA5A5_0001, b = 32'hA5A5_0000, bit_ready = 1. Required: bit_valid from cycle 1; sop only in cycle 1; bit_a/bit_b sequence = MSB-first of each operand; eop only in cycle 32 with bit_a = 1, bit_b = 0; done pulse in cycle 33; busy = 0 in cycle 34.
2. Same transfer, but bit_ready = 0 for 5 cycles while bit_idx = 7. Required: bit_a, bit_b, bit_idx = 7 and bit_valid all stable during the stall; total stream length is still 32 accepted pairs; done is delayed by exactly 5 cycles.
3. start pulsed at bit_idx = 10 with new operand values. Required: ignored; the stream continues with the original operands; exactly one done pulse.
4. res asserted at bit_idx = 20. Required: next cycle all outputs are 0, state is IDLE, no done pulse; a following start streams new operands correctly from sop.
5. Back-to-back: start held at 1 continuously with a = 32'hFFFF_FFFF, b = 0. Required: a new transfer begins in the cycle after each done (period = 34 cycles); each stream is bit_a = 1, bit_b = 0 for all 32 pairs.
6. WIDTH = 4, a = 4'b1001, b = 4'b1010, bit_ready alternating 1/0 each cycle. Required: accepted pairs (bit_a, bit_b) = (1,1), (0,0), (0,1), (1,0); eop seen on the 4th accepted pair; bit_idx is 2 bits wide.
